bcd_time_calendar: RTL and testbench

Parametrised BCD time-of-day and calendar counter. Tracks hh:mm:ss and dd/mm/yyyy with correct month lengths and leap years. Provides a button-driven set mode with per-field up/down, hold-to-repeat and day clamping. Sits between the board clock/buttons and the 7-segment decoders; outputs are packed BCD digits ready for per-digit decode.

---
 rtl/bcd_time_calendar.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_bcd_time_calendar.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_time_calendar.sv
// BCD hh:mm:ss + dd/mm/yyyy counter with a button-driven set mode and hold-to-repeat.
// Define BCD_CAL_GREGORIAN_EN for the full Gregorian leap rule (default: every 4th year is leap).
module bcd_time_calendar #(
  parameter int unsigned TICK_DIV   = 50_000_000,
  parameter int unsigned FAST_DIV   = 500,
  parameter int unsigned HOLD_DIV   = 25_000_000,
  parameter int unsigned REPEAT_DIV = 12_500_000,
  parameter logic [15:0] RESET_YEAR = 16'h2024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fast,
  input  logic        btn_sel_n,
  input  logic        btn_up_n,
  input  logic        btn_dn_n,
  output logic [23:0] time_bcd,
  output logic [31:0] date_bcd,
  output logic [2:0]  field,
  output logic        set_active,
  output logic        sec_pulse
);
  typedef enum logic [2:0] {
    F_RUN = 3'd0, F_SEC = 3'd1, F_MIN = 3'd2, F_HOUR = 3'd3,
    F_DAY = 3'd4, F_MON = 3'd5, F_YEAR = 3'd6
  } field_t;

  localparam int unsigned PMAX = (TICK_DIV > FAST_DIV) ? TICK_DIV : FAST_DIV;
  localparam int unsigned RMAX = (HOLD_DIV > REPEAT_DIV) ? HOLD_DIV : REPEAT_DIV;
  localparam int PW = $clog2(PMAX) + 1;
  localparam int RW = $clog2(RMAX) + 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] FAST_LAST = PW'(FAST_DIV - 1);
  localparam logic [RW-1:0] HOLD_LAST = RW'(HOLD_DIV - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_DIV - 1);

  // Two-digit BCD step with wrap; ordering of packed BCD matches numeric ordering.
  function automatic logic [7:0] inc2(input logic [7:0] v, input logic [7:0] hi, input logic [7:0] lo);
    if (v >= hi) return lo;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] dec2(input logic [7:0] v, input logic [7:0] hi, input logic [7:0] lo);
    if (v <= lo) return hi;
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  function automatic logic [15:0] inc4(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (v[i*4 +: 4] == 4'd9) r[i*4 +: 4] = 4'd0;
        else begin
          r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] dec4(input logic [15:0] v);
    logic [15:0] r;
    logic        b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (b) begin
        if (v[i*4 +: 4] == 4'd0) r[i*4 +: 4] = 4'd9;
        else begin
          r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Divisibility by 4 of a two-digit BCD number from the tens parity and the ones digit.
  function automatic logic div4(input logic tens_odd, input logic [3:0] ones);
    if (tens_odd) return (ones == 4'd2) || (ones == 4'd6);
    return (ones == 4'd0) || (ones == 4'd4) || (ones == 4'd8);
  endfunction

  function automatic logic [7:0] month_len(input logic [7:0] mo, input logic leap);
    case (mo)
      8'h02:                      return leap ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
      default:                    return 8'h31;
    endcase
  endfunction

  logic [2:0] btn_n, pressed;
  assign btn_n = {btn_dn_n, btn_up_n, btn_sel_n};

  for (genvar gi = 0; gi < 3; gi++) begin : g_sync
    logic s1_reg, s2_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_reg <= 1'b0;
        s2_reg <= 1'b0;
      end else begin
        s1_reg <= ~btn_n[gi];
        s2_reg <= s1_reg;
      end
    end
    assign pressed[gi] = s2_reg;
  end

  field_t          field_reg, field_next;
  logic [7:0]      sec_reg, min_reg, hour_reg, day_reg, mon_reg;
  logic [7:0]      sec_next, min_next, hour_next, day_next, mon_next;
  logic [15:0]     year_reg, year_next, year_set;
  logic [7:0]      mon_set, mlen_cur;
  logic            leap_cur, leap_set;
  logic [PW-1:0]   presc_reg, presc_next, div_last;
  logic [RW-1:0]   rep_cnt_reg, rep_cnt_next;
  logic            rep_en_reg, rep_en_next, rep_phase_reg, rep_phase_next;
  logic            sel_d_reg, up_d_reg, dn_d_reg, set_active_reg, sec_pulse_reg;
  logic            up_eff, dn_eff, sel_edge, up_edge, dn_edge, step_up, step_dn, tick;

  // Up and down held together cancel each other; releasing one yields a fresh edge on the other.
  assign up_eff   = pressed[1] & ~pressed[2];
  assign dn_eff   = pressed[2] & ~pressed[1];
  assign sel_edge = pressed[0] & ~sel_d_reg;
  assign up_edge  = up_eff & ~up_d_reg;
  assign dn_edge  = dn_eff & ~dn_d_reg;
  assign div_last = fast ? FAST_LAST : TICK_LAST;
  assign mlen_cur = month_len(mon_reg, leap_cur);

  always_comb begin
    rep_cnt_next   = rep_cnt_reg;
    rep_en_next    = rep_en_reg;
    rep_phase_next = rep_phase_reg;
    step_up        = 1'b0;
    step_dn        = 1'b0;
    if (sel_edge || !(up_eff || dn_eff)) begin
      rep_cnt_next   = '0;
      rep_en_next    = 1'b0;
      rep_phase_next = 1'b0;
    end else if (up_edge || dn_edge) begin
      rep_cnt_next   = '0;
      rep_en_next    = 1'b1;
      rep_phase_next = 1'b0;
      step_up        = up_edge;
      step_dn        = dn_edge;
    end else if (rep_en_reg) begin
      if (rep_cnt_reg == (rep_phase_reg ? REP_LAST : HOLD_LAST)) begin
        rep_cnt_next   = '0;
        rep_phase_next = 1'b1;
        step_up        = up_eff;
        step_dn        = dn_eff;
      end else begin
        rep_cnt_next = rep_cnt_reg + RW'(1);
      end
    end
  end

  always_comb begin
    field_next = field_reg;
    if (sel_edge) begin
      case (field_reg)
        F_RUN:   field_next = F_SEC;
        F_SEC:   field_next = F_MIN;
        F_MIN:   field_next = F_HOUR;
        F_HOUR:  field_next = F_DAY;
        F_DAY:   field_next = F_MON;
        F_MON:   field_next = F_YEAR;
        default: field_next = F_RUN;
      endcase
    end
  end

  always_comb begin
    year_set = step_up ? inc4(year_reg) : dec4(year_reg);
    mon_set  = step_up ? inc2(mon_reg, 8'h12, 8'h01) : dec2(mon_reg, 8'h12, 8'h01);
`ifdef BCD_CAL_GREGORIAN_EN
    leap_cur = (year_reg[7:0] == 8'h00) ? div4(year_reg[12], year_reg[11:8])
                                        : div4(year_reg[4], year_reg[3:0]);
    leap_set = (year_set[7:0] == 8'h00) ? div4(year_set[12], year_set[11:8])
                                        : div4(year_set[4], year_set[3:0]);
`else
    leap_cur = div4(year_reg[4], year_reg[3:0]);
    leap_set = div4(year_set[4], year_set[3:0]);
`endif
  end

  always_comb begin
    sec_next   = sec_reg;
    min_next   = min_reg;
    hour_next  = hour_reg;
    day_next   = day_reg;
    mon_next   = mon_reg;
    year_next  = year_reg;
    presc_next = '0;
    tick       = 1'b0;
    if (field_reg == F_RUN) begin
      tick       = (presc_reg >= div_last);
      presc_next = tick ? '0 : presc_reg + PW'(1);
      if (tick) begin
        sec_next = inc2(sec_reg, 8'h59, 8'h00);
        if (sec_reg >= 8'h59) begin
          min_next = inc2(min_reg, 8'h59, 8'h00);
          if (min_reg >= 8'h59) begin
            hour_next = inc2(hour_reg, 8'h23, 8'h00);
            if (hour_reg >= 8'h23) begin
              day_next = inc2(day_reg, mlen_cur, 8'h01);
              if (day_reg >= mlen_cur) begin
                mon_next = inc2(mon_reg, 8'h12, 8'h01);
                if (mon_reg >= 8'h12) year_next = inc4(year_reg);
              end
            end
          end
        end
      end
    end else if (step_up || step_dn) begin
      case (field_reg)
        F_SEC:  sec_next  = 8'h00;
        F_MIN:  min_next  = step_up ? inc2(min_reg, 8'h59, 8'h00) : dec2(min_reg, 8'h59, 8'h00);
        F_HOUR: hour_next = step_up ? inc2(hour_reg, 8'h23, 8'h00) : dec2(hour_reg, 8'h23, 8'h00);
        F_DAY:  day_next  = step_up ? inc2(day_reg, mlen_cur, 8'h01) : dec2(day_reg, mlen_cur, 8'h01);
        F_MON: begin
          mon_next = mon_set;
          if (day_reg > month_len(mon_set, leap_cur)) day_next = month_len(mon_set, leap_cur);
        end
        F_YEAR: begin
          year_next = year_set;
          if (day_reg > month_len(mon_reg, leap_set)) day_next = month_len(mon_reg, leap_set);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) field_reg <= F_RUN;
    else        field_reg <= field_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_reg        <= 8'h00;
      min_reg        <= 8'h00;
      hour_reg       <= 8'h00;
      day_reg        <= 8'h01;
      mon_reg        <= 8'h01;
      year_reg       <= RESET_YEAR;
      presc_reg      <= '0;
      rep_cnt_reg    <= '0;
      rep_en_reg     <= 1'b0;
      rep_phase_reg  <= 1'b0;
      sel_d_reg      <= 1'b0;
      up_d_reg       <= 1'b0;
      dn_d_reg       <= 1'b0;
      set_active_reg <= 1'b0;
      sec_pulse_reg  <= 1'b0;
    end else begin
      sec_reg        <= sec_next;
      min_reg        <= min_next;
      hour_reg       <= hour_next;
      day_reg        <= day_next;
      mon_reg        <= mon_next;
      year_reg       <= year_next;
      presc_reg      <= presc_next;
      rep_cnt_reg    <= rep_cnt_next;
      rep_en_reg     <= rep_en_next;
      rep_phase_reg  <= rep_phase_next;
      sel_d_reg      <= pressed[0];
      up_d_reg       <= up_eff;
      dn_d_reg       <= dn_eff;
      set_active_reg <= (field_next != F_RUN);
      sec_pulse_reg  <= tick;
    end
  end

  assign time_bcd   = {hour_reg, min_reg, sec_reg};
  assign date_bcd   = {day_reg, mon_reg, year_reg};
  assign field      = field_reg;
  assign set_active = set_active_reg;
  assign sec_pulse  = sec_pulse_reg;
endmodule

// File: tb/tb_bcd_time_calendar.sv
// Directed bench for bcd_time_calendar: rollovers, leap years, set mode, clamp, repeat, reset.
module tb_bcd_time_calendar;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fast = 1'b1;
  logic        btn_sel_n = 1'b1;
  logic        btn_up_n = 1'b1;
  logic        btn_dn_n = 1'b1;
  logic [23:0] time_bcd;
  logic [31:0] date_bcd;
  logic [2:0]  field;
  logic        set_active;
  logic        sec_pulse;

  int errors = 0;
  int checks = 0;
  localparam int SEL = 0, UP = 1, DN = 2;

`ifdef BCD_CAL_GREGORIAN_EN
  localparam logic [31:0] DATE_AFTER_2100 = 32'h01032100;
`else
  localparam logic [31:0] DATE_AFTER_2100 = 32'h29022100;
`endif

  bcd_time_calendar #(
    .TICK_DIV(10), .FAST_DIV(4), .HOLD_DIV(8), .REPEAT_DIV(4), .RESET_YEAR(16'h2024)
  ) dut (
    .clk(clk), .rst_n(rst_n), .fast(fast),
    .btn_sel_n(btn_sel_n), .btn_up_n(btn_up_n), .btn_dn_n(btn_dn_n),
    .time_bcd(time_bcd), .date_bcd(date_bcd), .field(field),
    .set_active(set_active), .sec_pulse(sec_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      SEL:     btn_sel_n = v;
      UP:      btn_up_n  = v;
      default: btn_dn_n  = v;
    endcase
  endtask

  // n steps from one continuous hold: first at edge 3, second 8 later, then every 4.
  task automatic hold(input int b, input int n);
    set_btn(b, 1'b0);
    step((n > 1) ? 4 * n + 3 : 3);
    set_btn(b, 1'b1);
    step(4);
  endtask

  task automatic press(input int b);
    hold(b, 1);
  endtask

  // From YEAR: leave set mode, run from xx:xx:00 through :59 and one more tick.
  task automatic exit_and_roll(input string tag, input logic [31:0] d_before, input logic [31:0] d_after);
    set_btn(SEL, 1'b0);
    step(3);
    set_btn(SEL, 1'b1);
    check({tag, "_run"}, field, 0);
    step(4 * 59);
    check({tag, "_t59"}, time_bcd, 24'h235959);
    check({tag, "_d59"}, date_bcd, d_before);
    step(4);
    check({tag, "_t0"}, time_bcd, 24'h000000);
    check({tag, "_d0"}, date_bcd, d_after);
    check({tag, "_pulse"}, sec_pulse, 1);
  endtask

  // Walk SEC (clear), MIN and HOUR down once from 00 to reach 23:59:00.
  task automatic set_time_2359();
    press(SEL); press(UP);
    press(SEL); press(DN);
    press(SEL); press(DN);
  endtask

  initial begin
    step(3);
    check("rst_time", time_bcd, 24'h000000);
    check("rst_date", date_bcd, 32'h01012024);
    check("rst_field", field, 0);
    check("rst_set", set_active, 0);
    check("rst_pulse", sec_pulse, 0);
    rst_n = 1'b1;

    for (int k = 1; k <= 3; k++) begin
      step(3);
      check("pulse_lo", sec_pulse, 0);
      step(1);
      check("pulse_hi", sec_pulse, 1);
      check("tick_time", time_bcd, 64'(k));
    end

    // New year: 31/12/2024 23:59:59 -> 01/01/2025
    press(SEL);
    check("sec_field", field, 1);
    check("sec_active", set_active, 1);
    check("sec_frozen", time_bcd, 24'h000003);
    press(UP);
    check("sec_clr", time_bcd, 24'h000000);
    press(SEL); press(DN);
    press(SEL); press(DN);
    press(SEL); press(DN);
    press(SEL); press(DN);
    check("nye_time", time_bcd, 24'h235900);
    check("nye_date", date_bcd, 32'h31122024);
    press(SEL);
    exit_and_roll("newyear", 32'h31122024, 32'h01012025);

    // Leap February 2024, with month-change clamp on the way
    set_time_2359();
    press(SEL); press(DN);
    press(SEL); press(UP);
    check("clamp_feb25", date_bcd, 32'h28022025);
    press(SEL); press(DN);
    check("yr_dn", date_bcd, 32'h28022024);
    exit_and_roll("leap24", 32'h28022024, 32'h29022024);

    // Non-leap February 2023, with year-change on 28th
    set_time_2359();
    press(SEL); press(DN);
    press(SEL);
    press(SEL); press(DN);
    check("feb23_set", date_bcd, 32'h28022023);
    exit_and_roll("feb23", 32'h28022023, 32'h01032023);

    // 31/03/2023, month down clamps to 28/02/2023; then year repeat up to 2100
    set_time_2359();
    press(SEL); press(DN);
    check("day_wrap", date_bcd, 32'h31032023);
    press(SEL); press(DN);
    check("mon_clamp", date_bcd, 32'h28022023);
    check("mon_field", field, 5);
    check("mon_active", set_active, 1);
    step(20);
    check("frozen_t", time_bcd, 24'h235900);
    press(SEL);
    hold(UP, 77);
    check("yr_repeat", date_bcd, 32'h28022100);
    exit_and_roll("y2100", 32'h28022100, DATE_AFTER_2100);

    // Hold-to-repeat in MIN from 58
    press(SEL); press(SEL); press(DN); press(DN);
    check("min58", time_bcd, 24'h005800);
    btn_up_n = 1'b0;
    step(3);  check("rep_first", time_bcd, 24'h005900);
    step(7);  check("rep_hold", time_bcd, 24'h005900);
    step(1);  check("rep_wrap", time_bcd, 24'h000000);
    step(3);  check("rep_gap", time_bcd, 24'h000000);
    step(1);  check("rep_01", time_bcd, 24'h000100);
    step(4);  check("rep_02", time_bcd, 24'h000200);
    btn_up_n = 1'b1;
    step(4);  check("rep_rel", time_bcd, 24'h000200);

    // Up and down together in HOUR
    press(SEL);
    btn_up_n = 1'b0;
    btn_dn_n = 1'b0;
    step(100);
    check("both_held", time_bcd, 24'h000200);
    btn_dn_n = 1'b1;
    step(3);  check("dn_release", time_bcd, 24'h010200);
    step(4);  check("single_step", time_bcd, 24'h010200);
    btn_up_n = 1'b1;
    step(4);

    // Asynchronous reset in the middle of a YEAR repeat
    press(SEL); press(SEL); press(SEL);
    check("year_field", field, 6);
    btn_up_n = 1'b0;
    step(14);
    check("yr_mid", date_bcd[15:0], 16'h2102);
    rst_n = 1'b0;
    #1;
    check("arst_time", time_bcd, 24'h000000);
    check("arst_date", date_bcd, 32'h01012024);
    check("arst_field", field, 0);
    check("arst_set", set_active, 0);
    btn_up_n = 1'b1;
    step(3);

    // Normal prescale, then switch to fast with the prescaler already past FAST_DIV-1
    fast = 1'b0;
    rst_n = 1'b1;
    step(9);  check("slow_wait", time_bcd, 24'h000000);
    step(1);  check("slow_tick", time_bcd, 24'h000001);
    step(6);
    fast = 1'b1;
    step(1);  check("fast_switch", time_bcd, 24'h000002);
    check("fast_pulse", sec_pulse, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
